arc4_core_p: RTL and testbench
==============================

Name: arc4_core_p

Overview:
- Parametrised successor to the fixed 24-bit-key ARC4 decrypt pipeline.
- Runs S-box init, KSA and PRGA under one controller, for any key length from 1 to 16 bytes.
- Drives an external 256x8 S RAM, a length-prefixed ciphertext RAM and a plaintext RAM. All three are synchronous single-port RAMs with 1-cycle read latency.
- Sits under the phase-level top in place of the separate init/ksa/prga trio and keeps the same en/rdy handshake.

Parameters:
- KEY_BYTES, 3: key length in bytes, legal range 1..16.
- DROP_N, 0: number of initial keystream bytes discarded; used only when ARC4_DROP_EN is defined. Legal range 0..1024.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8]; latched on accepted en.
- s_addr  out  8  S RAM address.
- s_rddata  in  8  S RAM read data.
- s_wrdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- ct_addr  out  8  ciphertext RAM address.
- ct_rddata  in  8  ciphertext RAM read data.
- pt_addr  out  8  plaintext RAM address.
- pt_wrdata  out  8  plaintext RAM write data.
- pt_wren  out  1  plaintext RAM write enable.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rdy=1.
  - All wren=0; all addresses and write data = 0.
  - Internal i, j, k counters = 0.
- Handshake:
  - en accepted on a rising edge when rdy=1 and en=1; rdy falls the next cycle.
  - en while rdy=0 is ignored.
  - rdy returns to 1 the cycle after the last pt write; no new job starts in that same cycle.
- Read timing: any RAM read issued at cycle t returns valid data at t+1. The controller must insert a wait state; read data is never used combinationally from the same-cycle address.
- States: IDLE -> INIT -> KSA -> (DROP) -> LEN -> PRGA -> IDLE.
- INIT:
  - Writes S[i]=i for i=0..255, one write per cycle, exactly 256 cycles.
- KSA, for i=0..255:
  - j = j + S[i] + key[i mod KEY_BYTES], mod 256.
  - Swap S[i] and S[j].
  - The key byte index uses a wrapping counter, not a divider.
  - When i==j, both writes store the same value; the result must equal the unswapped S.
- LEN:
  - Read ct[0] into message_length (0..255).
  - Write pt[0]=ct[0].
  - message_length=0 goes straight to IDLE.
- PRGA, for k=1..message_length:
  - i = i + 1, mod 256.
  - j = j + S[i], mod 256.
  - Swap S[i] and S[j].
  - pad = S[(S[i]+S[j]) mod 256].
  - Write pt[k] = ct[k] ^ pad.
  - i and j restart at 0 when PRGA begins; they do not carry over from KSA.
- Width rules:
  - All index sums are 8-bit wrap.
  - message_length and k are held in 9 bits, so k=255 terminates cleanly.
- Bus exclusivity: at most one of s_wren and pt_wren is asserted per cycle; S reads and writes never overlap.
- Reset mid-operation: abort immediately to IDLE. RAM contents are left partially updated; the next job's INIT rebuilds S.
- The key is latched at accept; later changes on key have no effect until the next accept.

Optional Feature:
- Macro: ARC4_DROP_EN.
- Defined:
  - A DROP state between KSA and LEN runs DROP_N full PRGA steps (i, j update and swap) with no pt writes.
  - PRGA then continues i and j from DROP rather than resetting them.
  - DROP_N=0 must be cycle-identical to the undefined build.
- Undefined: no DROP state, DROP_N is ignored, and the state encoding omits DROP.

Decomposition:
- Package arc4_pkg:
  - state enum arc4_state_t (IDLE, INIT, KSA, DROP, LEN, PRGA plus read-wait substates).
  - S_SIZE=256.
  - KEY_BYTES_MAX=16.
  - localparam for the length index width (9).
- Sub-module arc4_key_byte:
  - Takes the latched key vector plus a wrapping byte counter.
  - Outputs the current 8-bit key byte.
  - Increments when the KSA step advances, wraps at KEY_BYTES-1, and resets to 0 at KSA entry.

Test Plan:
- KEY_BYTES=3, key=24'h4B6579 ("Key"), ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> pt={09,"Plaintext"}, rdy rises once, then stays 1.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), ct={05,10,21,BF,04,20} -> pt={05,"pedia"}; a second job with the same inputs gives an identical pt.
- KEY_BYTES=6, key="Secret", ct={0E,45,A0,1F,64,5F,C3,5B,38,35,52,54,4B,9B,F5} -> pt={0E,"Attack at dawn"}.
- ct[0]=00 -> only pt[0]=00 is written (single pt_wren pulse), and rdy returns.
- en pulsed during KSA -> ignored with no restart. rst asserted in PRGA -> rdy=1 and all wren=0 immediately; a restarted job then produces the correct pt.
- ARC4_DROP_EN with DROP_N=0 -> pt and cycle count identical to the baseline build. With DROP_N=256 -> no pt writes during DROP, and pt differs from baseline.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared constants and controller state encoding for the ARC4 decrypt core.
// The optional DROP state is part of the encoding only when ARC4_DROP_EN is defined.
package arc4_pkg;

  localparam int unsigned S_SIZE        = 256;
  localparam int unsigned KEY_BYTES_MAX = 16;
  localparam int unsigned LEN_W         = 9;  // message_length / k, so k=255 compares cleanly
  localparam int unsigned KIDX_W        = $clog2(KEY_BYTES_MAX);

  // Each S access is split into an address-issue state and a data-use state,
  // because the RAMs return read data one cycle after the address.
  typedef enum logic [4:0] {
    StIdle,
    StInit,
    StKsa,        // issue read S[i]
    StKsaCalcJ,   // S[i] valid: update j
    StKsaReadJ,   // issue read S[j]
    StKsaWrI,     // S[j] valid: S[i] <= S[j]
    StKsaWrJ,     // S[j] <= old S[i]
    StLen,        // issue read ct[0]
    StLenWr,      // ct[0] valid: latch length, pt[0] <= ct[0]
    StPrga,       // i++, issue read S[i]
    StPCalcJ,
    StPReadJ,
    StPWrI,
    StPWrJ,
    StPReadPad,   // issue read S[S[i]+S[j]] and ct[k]
    StPWrPt       // pt[k] <= ct[k] ^ pad
`ifdef ARC4_DROP_EN
    , StDrop      // same step as StPrga, but the step ends without a pt write
`endif
  } arc4_state_t;

endpackage

// File: rtl/arc4_key_byte.sv
// Key byte selector for KSA.
// Keeps a wrapping byte index into the latched key and presents the selected byte.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         restart the index at byte 0 (KSA entry)
//   adv_i         advance the index (one KSA step completed)
//   key_i         latched key, byte 0 in the most significant byte
//   key_byte_o    key[idx]
module arc4_key_byte
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   adv_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic [7:0]             key_byte_o
);

  localparam logic [KIDX_W-1:0] LastIdx = KIDX_W'(KEY_BYTES - 1);

  logic [KIDX_W-1:0] idx_q, idx_d;

  // Wrapping counter instead of i mod KEY_BYTES.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  always_comb begin
    key_byte_o = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (idx_q == KIDX_W'(b)) begin
        key_byte_o = key_i[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

endmodule

// File: rtl/arc4_core_p.sv
// ARC4 decrypt core: S-box init, KSA and PRGA under one controller.
// Drives external synchronous single-port RAMs (1-cycle read latency):
//   S (256x8), ciphertext (length-prefixed) and plaintext.
// Optional feature macro: ARC4_DROP_EN adds a DROP phase that discards DROP_N
// keystream bytes after KSA; PRGA then continues i/j from where DROP left them.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en / rdy            start request / idle; en is taken only while rdy=1
//   key                 key, byte 0 = key[8*KEY_BYTES-1 -: 8], latched on accept
//   s_addr/s_rddata/s_wrdata/s_wren   S RAM
//   ct_addr/ct_rddata                 ciphertext RAM
//   pt_addr/pt_wrdata/pt_wren         plaintext RAM
module arc4_core_p
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam logic [7:0] LastIdx = 8'(S_SIZE - 1);

  arc4_state_t            state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [LEN_W-1:0]       k_q, k_d, len_q, len_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             key_byte;
  logic                   kb_clr, kb_adv;

`ifdef ARC4_DROP_EN
  logic        drop_q, drop_d;
  logic [10:0] dcnt_q, dcnt_d;
`else
  logic unused_drop_n;
  assign unused_drop_n = (DROP_N != 0);
`endif

  arc4_key_byte #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_byte (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (kb_clr),
    .adv_i      (kb_adv),
    .key_i      (key_q),
    .key_byte_o (key_byte)
  );

  assign rdy = (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    key_d     = key_q;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    kb_clr    = 1'b0;
    kb_adv    = 1'b0;
`ifdef ARC4_DROP_EN
    drop_d    = drop_q;
    dcnt_d    = dcnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (en) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;  // wraps to 0 for KSA
        if (i_q == LastIdx) begin
          j_d     = '0;
          kb_clr  = 1'b1;
          state_d = StKsa;
        end
      end
      StKsa: begin
        s_addr  = i_q;
        state_d = StKsaCalcJ;
      end
      StKsaCalcJ: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte;
        state_d = StKsaReadJ;
      end
      StKsaReadJ: begin
        s_addr  = j_q;
        state_d = StKsaWrI;
      end
      StKsaWrI: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = StKsaWrJ;
      end
      StKsaWrJ: begin
        // With i==j both writes carry the original S[i], leaving S unchanged.
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        kb_adv   = 1'b1;
        i_d      = i_q + 8'd1;
        state_d  = StKsa;
        if (i_q == LastIdx) begin
          i_d     = '0;
          j_d     = '0;
          state_d = StLen;
`ifdef ARC4_DROP_EN
          if (DROP_N != 0) begin
            drop_d  = 1'b1;
            dcnt_d  = '0;
            state_d = StDrop;
          end
`endif
        end
      end
      StLen: begin
        ct_addr = '0;
        state_d = StLenWr;
      end
      StLenWr: begin
        len_d     = {1'b0, ct_rddata};
        pt_addr   = '0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        k_d       = 9'd1;
        state_d   = (ct_rddata == 8'd0) ? StIdle : StPrga;
      end
`ifdef ARC4_DROP_EN
      StDrop,
`endif
      StPrga: begin
        s_addr  = i_q + 8'd1;
        i_d     = i_q + 8'd1;
        state_d = StPCalcJ;
      end
      StPCalcJ: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = StPReadJ;
      end
      StPReadJ: begin
        s_addr  = j_q;
        state_d = StPWrI;
      end
      StPWrI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = StPWrJ;
      end
      StPWrJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = StPReadPad;
`ifdef ARC4_DROP_EN
        if (drop_q) begin
          dcnt_d = dcnt_q + 11'd1;
          if (dcnt_d == 11'(DROP_N)) begin
            drop_d  = 1'b0;
            state_d = StLen;
          end else begin
            state_d = StDrop;
          end
        end
`endif
      end
      StPReadPad: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q[7:0];
        state_d = StPWrPt;
      end
      StPWrPt: begin
        pt_addr   = k_q[7:0];
        pt_wrdata = ct_rddata ^ s_rddata;
        pt_wren   = 1'b1;
        k_d       = k_q + 9'd1;
        state_d   = (k_q == len_q) ? StIdle : StPrga;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
`ifdef ARC4_DROP_EN
      drop_q  <= 1'b0;
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
`ifdef ARC4_DROP_EN
      drop_q  <= drop_d;
      dcnt_q  <= dcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_arc4_core_p.sv
// Directed bench for arc4_core_p: three instances (3-, 4- and 6-byte keys), each with
// its own S, ciphertext and plaintext RAM models of 1-cycle read latency.
module tb_arc4_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  en, rdy, s_wren, pt_wren;
  logic [7:0]  s_addr[3], s_rddata[3], s_wrdata[3];
  logic [7:0]  ct_addr[3], ct_rddata[3], pt_addr[3], pt_wrdata[3];
  logic [23:0] key3;
  logic [31:0] key4;
  logic [47:0] key6;

  logic [7:0]  s_mem[3][256];
  logic [7:0]  ct_mem[3][256];
  logic [7:0]  pt_mem[3][256];
  logic [2:0]  pt_clr, rdy_prev;
  int          pt_cnt[3];
  int          rise_cnt[3];

  int n_checks = 0;
  int n_errs   = 0;

  arc4_core_p #(.KEY_BYTES(3)) u_dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key3),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  arc4_core_p #(.KEY_BYTES(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key4),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  arc4_core_p #(.KEY_BYTES(6)) u_dut2 (
    .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .key(key6),
    .s_addr(s_addr[2]), .s_rddata(s_rddata[2]), .s_wrdata(s_wrdata[2]), .s_wren(s_wren[2]),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rddata[2]),
    .pt_addr(pt_addr[2]), .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2])
  );

  // RAM models plus write / rdy-rise counters, cleared on pt_clr.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (s_wren[n]) s_mem[n][s_addr[n]] <= s_wrdata[n];
      s_rddata[n]  <= s_mem[n][s_addr[n]];
      ct_rddata[n] <= ct_mem[n][ct_addr[n]];
      rdy_prev[n]  <= rdy[n];
      if (pt_clr[n]) begin
        for (int m = 0; m < 256; m++) pt_mem[n][m] <= 8'hFF;
        pt_cnt[n]   <= 0;
        rise_cnt[n] <= 0;
      end else begin
        if (pt_wren[n]) begin
          pt_mem[n][pt_addr[n]] <= pt_wrdata[n];
          pt_cnt[n]             <= pt_cnt[n] + 1;
        end
        if (rdy[n] && !rdy_prev[n]) rise_cnt[n] <= rise_cnt[n] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_job(input int n, input logic [127:0] ct_v, input int nb);
    for (int m = 0; m < 256; m++) ct_mem[n][m] = 8'h00;
    for (int m = 0; m < nb; m++) ct_mem[n][m] = ct_v[8*(nb-1-m) +: 8];
    pt_clr[n] = 1'b1;
    @(posedge clk);
    #1 pt_clr[n] = 1'b0;
  endtask

  task automatic check_pt(input int n, input string name, input logic [127:0] pt_v,
                          input int nb);
    for (int m = 0; m < nb; m++)
      check_eq($sformatf("%s_pt%0d", name, m), pt_mem[n][m], pt_v[8*(nb-1-m) +: 8]);
    check_eq($sformatf("%s_pt_beyond", name), pt_mem[n][nb], 8'hFF);
    check_eq($sformatf("%s_pt_writes", name), pt_cnt[n], nb);
  endtask

  // Start a job on instance n and count cycles from the accept edge until rdy.
  // glitch: pulse en at cycle 600 (inside KSA) and corrupt the key input at cycle 10.
  // rst_at: assert reset at that cycle and return after checking the abort.
  task automatic run_job(input int n, input bit glitch, input int rst_at, output int cycles);
    logic [23:0] key_save;
    key_save = key3;
    cycles   = 0;
    en[n] = 1'b1;
    @(posedge clk);
    #1 en[n] = 1'b0;
    check_eq("rdy_fall", rdy[n], 1'b0);
    while (!rdy[n] && cycles < 4000) begin
      @(posedge clk);
      #1 cycles++;
      if (glitch) begin
        en[n] = (cycles == 600);
        if (cycles == 10) key3 = ~key_save;
      end
      if (cycles == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_rdy", rdy[n], 1'b1);
        check_eq("rst_s_wren", s_wren[n], 1'b0);
        check_eq("rst_pt_wren", pt_wren[n], 1'b0);
        check_eq("rst_s_addr", s_addr[n], 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        key3 = key_save;
        return;
      end
    end
    en[n] = 1'b0;
    key3  = key_save;
    check_eq("job_done", rdy[n], 1'b1);
  endtask

  localparam logic [79:0]  CtKey    = 80'h09_BBF316E8D940AF0AD3;
  localparam logic [47:0]  CtWiki   = 48'h05_1021BF0420;
  localparam logic [119:0] CtSecret = 120'h0E_45A01F645FC35B383552544B9BF5;

  initial begin
    int cyc;
    logic [79:0]  pt_key;
    logic [47:0]  pt_wiki;
    logic [119:0] pt_secret;
    pt_key    = {8'h09, "Plaintext"};
    pt_wiki   = {8'h05, "pedia"};
    pt_secret = {8'h0E, "Attack at dawn"};

    rst    = 1'b1;
    en     = '0;
    pt_clr = '0;
    key3   = 24'h4B6579;
    key4   = 32'h57696B69;
    key6   = "Secret";
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rdy", rdy, 3'b111);
    check_eq("reset_s_wren", s_wren, 3'b000);
    check_eq("reset_pt_wren", pt_wren, 3'b000);
    check_eq("reset_s_addr", s_addr[0], 8'h00);
    check_eq("reset_s_wrdata", s_wrdata[1], 8'h00);
    check_eq("reset_pt_addr", pt_addr[2], 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "Key" / "Plaintext": 256 init + 256*5 KSA + 2 LEN + 9*7 PRGA cycles
    load_job(0, CtKey, 10);
    run_job(0, 1'b0, -1, cyc);
    check_eq("key_cycles", cyc, 1601);
    check_pt(0, "key", pt_key, 10);
    repeat (20) @(posedge clk);
    #1;
    check_eq("key_rdy_stays", rdy[0], 1'b1);
    check_eq("key_rdy_rises", rise_cnt[0], 1);

    // "Wiki" / "pedia", run twice
    load_job(1, CtWiki, 6);
    run_job(1, 1'b0, -1, cyc);
    check_eq("wiki_cycles", cyc, 1573);
    check_pt(1, "wiki", pt_wiki, 6);
    load_job(1, CtWiki, 6);
    run_job(1, 1'b0, -1, cyc);
    check_pt(1, "wiki2", pt_wiki, 6);

    // "Secret" / "Attack at dawn"
    load_job(2, CtSecret, 15);
    run_job(2, 1'b0, -1, cyc);
    check_eq("secret_cycles", cyc, 1636);
    check_pt(2, "secret", pt_secret, 15);

    // Zero-length message: only pt[0] written
    load_job(0, 128'h00, 1);
    run_job(0, 1'b0, -1, cyc);
    check_eq("zero_cycles", cyc, 1538);
    check_pt(0, "zero", 128'h00, 1);

    // en during KSA ignored, key changes after accept ignored
    load_job(0, CtKey, 10);
    run_job(0, 1'b1, -1, cyc);
    check_eq("glitch_cycles", cyc, 1601);
    check_pt(0, "glitch", pt_key, 10);

    // Reset in PRGA, then a clean restart
    load_job(0, CtKey, 10);
    run_job(0, 1'b0, 1560, cyc);
    load_job(0, CtKey, 10);
    run_job(0, 1'b0, -1, cyc);
    check_eq("restart_cycles", cyc, 1601);
    check_pt(0, "restart", pt_key, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
